// File: rtl/gated_rr_source_pkg.sv
// Shared types and helpers for the gated round-robin source.
// Pure declarations; no logic, no latency.
// Imported by the arbiter, the interface and the top.
package gated_src_pkg;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 4;

    // Round-robin successor of grant index g among n channels.
    function automatic int next_ptr(input int g, input int n);
        return (g == n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/gated_rr_source_if.sv
// Channel request side and registered output side of gated_rr_source.
// master = the source block, slave = the surrounding environment.
// y_valid/y_ready handshake on the output; accept acknowledges channel words.
interface gated_rr_source_if
    import gated_src_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
);
    localparam int CW = $clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] x_in;
    logic [CHANNELS-1:0]       flag;
    logic [CHANNELS-1:0]       accept;
    logic [WIDTH-1:0]          y_out;
    logic [CW-1:0]             y_chan;
    logic                      y_valid;
    logic                      y_ready;

    modport master (
        input  x_in, flag, y_ready,
        output accept, y_out, y_chan, y_valid
    );

    modport slave (
        output x_in, flag, y_ready,
        input  accept, y_out, y_chan, y_valid
    );

endinterface

// File: rtl/gated_rr_source_rr_arbiter.sv
// Round-robin arbiter: first set req at or above ptr, wrapping N-1 -> 0.
// Latency: purely combinational.
// Backpressure: none here; the caller qualifies the grant.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int CW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [CW-1:0] gidx,
    output logic          any
);

    always_comb begin
        logic found;
        int   j;
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                gidx     = CW'(j);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/gated_rr_source.sv
// Round-robin picks one flagged channel word per cycle into a one-deep output register.
// Latency: word accepted at edge N is on y_out after edge N; one word per cycle when y_ready stays high.
// Backpressure: y_ready=0 while full holds y_out/y_chan/rr_ptr and blocks accept. GATED_SRC_STATS_EN adds xfer_count.
module gated_rr_source
    import gated_src_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    localparam int CW      = $clog2(CHANNELS)
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef GATED_SRC_STATS_EN
    gated_rr_source_if.master  bus,
    output logic [15:0]        xfer_count
`else
    gated_rr_source_if.master  bus
`endif
);

    state_t              state_q, state_d;
    logic [CW-1:0]       rr_ptr_q;
    logic [WIDTH-1:0]    y_out_q;
    logic [CW-1:0]       y_chan_q;

    logic [CHANNELS-1:0] grant;
    logic [CW-1:0]       gidx;
    logic                any_req;
    logic                can_load;
    logic                load;
    logic                drain;

    rr_arbiter #(
        .N  (CHANNELS),
        .CW (CW)
    ) u_arb (
        .req   (bus.flag),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .gidx  (gidx),
        .any   (any_req)
    );

    // rst_n gates the load so no channel sees an accept that reset will discard.
    assign can_load = (state_q == ST_EMPTY) | bus.y_ready;
    assign load     = can_load & any_req & rst_n;
    assign drain    = (state_q == ST_FULL) & bus.y_ready & ~any_req;

    assign bus.accept  = grant & {CHANNELS{load}};
    assign bus.y_valid = (state_q == ST_FULL);
    assign bus.y_out   = y_out_q;
    assign bus.y_chan  = y_chan_q;

    always_comb begin
        state_d = state_q;
        if (load)       state_d = ST_FULL;
        else if (drain) state_d = ST_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_out_q  <= '0;
            y_chan_q <= '0;
            rr_ptr_q <= '0;
        end else if (load) begin
            y_out_q  <= bus.x_in[int'(gidx)*WIDTH +: WIDTH];
            y_chan_q <= gidx;
            rr_ptr_q <= CW'(next_ptr(int'(gidx), CHANNELS));
        end else if (drain) begin
            y_out_q  <= '0;
            y_chan_q <= '0;
        end
    end

`ifdef GATED_SRC_STATS_EN
    logic [15:0] xfer_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            xfer_cnt_q <= '0;
        else if (bus.y_valid && bus.y_ready && (xfer_cnt_q != 16'hFFFF))
            xfer_cnt_q <= xfer_cnt_q + 16'd1;
    end

    assign xfer_count = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_gated_rr_source.sv
// Bench for gated_rr_source: vector table, hand sequences, randomized model phase.
module tb_gated_rr_source;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    gated_rr_source_if #(.WIDTH(8), .CHANNELS(4)) bus ();

`ifdef GATED_SRC_STATS_EN
    logic [15:0] xfer_count;
    gated_rr_source #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .xfer_count (xfer_count)
    );
`else
    gated_rr_source #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [7:0] o;
        logic [1:0] c;
    } exp_t;

    typedef struct {
        logic        rst_n;
        logic [3:0]  flag;
        logic [31:0] x;
        logic        rdy;
        logic [3:0]  acc;
        logic        v;
        logic [7:0]  o;
        logic [1:0]  c;
        string       name;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive at negedge, check accept before the edge, check outputs after it.
    task automatic step(input logic r, input logic [3:0] f, input logic [31:0] x, input logic rdy,
                        input logic [3:0] eacc, input logic ev, input logic [7:0] eo,
                        input logic [1:0] ec, input string name);
        exp_t e;
        @(negedge clk);
        rst_n       = r;
        bus.flag    = f;
        bus.x_in    = x;
        bus.y_ready = rdy;
        #1;
        chk({name, ".accept"}, 32'(bus.accept), 32'(eacc));
        sb_q.push_back('{v: ev, o: eo, c: ec});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.scoreboard: got empty queue expected an entry", name);
        end else begin
            e = sb_q.pop_front();
            chk({name, ".y_valid"}, 32'(bus.y_valid), 32'(e.v));
            chk({name, ".y_out"},   32'(bus.y_out),   32'(e.o));
            chk({name, ".y_chan"},  32'(bus.y_chan),  32'(e.c));
        end
    endtask

    function automatic void add(input logic r, input logic [3:0] f, input logic [31:0] x,
                                input logic rdy, input logic [3:0] acc, input logic v,
                                input logic [7:0] o, input logic [1:0] c, input string name);
        vecs.push_back('{rst_n: r, flag: f, x: x, rdy: rdy, acc: acc, v: v, o: o, c: c, name: name});
    endfunction

    function automatic int rr_pick(input logic [3:0] f, input int p);
        for (int k = 0; k < 4; k++) begin
            if (f[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    localparam logic [31:0] X_ALL = 32'h13121110;

    initial begin
        logic       m_v;
        logic [7:0] m_o;
        logic [1:0] m_c;
        int         m_p;

        rst_n       = 1'b0;
        bus.flag    = '0;
        bus.x_in    = '0;
        bus.y_ready = 1'b0;

        // reset, single channel, drain, round-robin, sparse wrap
        add(0, 4'b1111, X_ALL,        1, 4'b0000, 0, 8'h00, 2'd0, "rst0");
        add(0, 4'b1111, X_ALL,        1, 4'b0000, 0, 8'h00, 2'd0, "rst1");
        add(1, 4'b0000, X_ALL,        1, 4'b0000, 0, 8'h00, 2'd0, "rel");
        add(1, 4'b0100, 32'h00A50000, 1, 4'b0100, 1, 8'hA5, 2'd2, "single");
        add(1, 4'b0000, 32'h00A50000, 1, 4'b0000, 0, 8'h00, 2'd0, "drain");
        add(0, 4'b0000, X_ALL,        1, 4'b0000, 0, 8'h00, 2'd0, "rst2");
        add(1, 4'b1111, X_ALL,        1, 4'b0001, 1, 8'h10, 2'd0, "rr0");
        add(1, 4'b1111, X_ALL,        1, 4'b0010, 1, 8'h11, 2'd1, "rr1");
        add(1, 4'b1111, X_ALL,        1, 4'b0100, 1, 8'h12, 2'd2, "rr2");
        add(1, 4'b1111, X_ALL,        1, 4'b1000, 1, 8'h13, 2'd3, "rr3");
        add(1, 4'b1111, X_ALL,        1, 4'b0001, 1, 8'h10, 2'd0, "rr4");
        add(1, 4'b1111, X_ALL,        1, 4'b0010, 1, 8'h11, 2'd1, "rr5");
        add(1, 4'b1010, X_ALL,        1, 4'b1000, 1, 8'h13, 2'd3, "sparse0");
        add(1, 4'b1010, X_ALL,        1, 4'b0010, 1, 8'h11, 2'd1, "sparse1");
        add(1, 4'b0001, X_ALL,        1, 4'b0001, 1, 8'h10, 2'd0, "wrap");

        foreach (vecs[i])
            step(vecs[i].rst_n, vecs[i].flag, vecs[i].x, vecs[i].rdy,
                 vecs[i].acc, vecs[i].v, vecs[i].o, vecs[i].c, vecs[i].name);

        // backpressure: ch1 held through a 5-cycle stall, then ch2 is next
        step(0, 4'b0000, X_ALL,        1, 4'b0000, 0, 8'h00, 2'd0, "bp_rst");
        step(1, 4'b0010, 32'h00003C00, 1, 4'b0010, 1, 8'h3C, 2'd1, "bp_load");
        for (int i = 0; i < 5; i++)
            step(1, 4'b1111, X_ALL, 0, 4'b0000, 1, 8'h3C, 2'd1, "bp_stall");
        step(1, 4'b1111, X_ALL, 1, 4'b0100, 1, 8'h12, 2'd2, "bp_release");

        // reset while stalled drops the word and restarts the pointer
        step(1, 4'b1111, X_ALL, 0, 4'b0000, 1, 8'h12, 2'd2, "ms_stall");
        step(0, 4'b1111, X_ALL, 0, 4'b0000, 0, 8'h00, 2'd0, "ms_rst");
        step(1, 4'b1111, X_ALL, 0, 4'b0001, 1, 8'h10, 2'd0, "ms_after");

        // randomized traffic against a behavioural model
        step(0, 4'b0000, X_ALL, 1, 4'b0000, 0, 8'h00, 2'd0, "rnd_rst");
        m_v = 0; m_o = 0; m_c = 0; m_p = 0;
        for (int i = 0; i < 200; i++) begin
            logic        r, rdy;
            logic [3:0]  f, acc;
            logic [31:0] x;
            int          g;
            r   = ($urandom_range(0, 29) != 0);
            f   = 4'($urandom_range(0, 15));
            rdy = ($urandom_range(0, 3) != 0);
            x   = $urandom;
            acc = '0;
            if (!r) begin
                m_v = 0; m_o = 0; m_c = 0; m_p = 0;
            end else if ((!m_v || rdy) && (f != 0)) begin
                g      = rr_pick(f, m_p);
                acc[g] = 1'b1;
                m_v    = 1;
                m_o    = x[g*8 +: 8];
                m_c    = 2'(g);
                m_p    = (g + 1) % 4;
            end else if (m_v && rdy) begin
                m_v = 0; m_o = 0; m_c = 0;
            end
            step(r, f, x, rdy, acc, m_v, m_o, m_c, "rnd");
        end

`ifdef GATED_SRC_STATS_EN
        step(0, 4'b0000, 32'h000000AA, 1, 4'b0000, 0, 8'h00, 2'd0, "st_rst");
        chk("st_reset_count", 32'(xfer_count), 32'd0);
        for (int i = 0; i < 11; i++)
            step(1, 4'b0001, 32'h000000AA, 1, 4'b0001, 1, 8'hAA, 2'd0, "st_load");
        step(1, 4'b0000, 32'h000000AA, 0, 4'b0000, 1, 8'hAA, 2'd0, "st_hold");
        chk("st_count10", 32'(xfer_count), 32'd10);
        @(negedge clk);
        dut.xfer_cnt_q = 16'hFFFE;
        for (int i = 0; i < 3; i++)
            step(1, 4'b0001, 32'h000000AA, 1, 4'b0001, 1, 8'hAA, 2'd0, "st_sat");
        chk("st_saturate", 32'(xfer_count), 32'h0000FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
